// File: rtl/xbus_fifo_link.sv
// Buffered XBus channel between two x-pins: a DEPTH-word FIFO with optional
// +/-999 clamping, a strobed flush and an occupancy output.
module xbus_fifo_link #(
  parameter int WIDTH    = 11,
  parameter int DEPTH    = 4,
  parameter int SATURATE = 1,
  parameter int LVL_W    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             posedge_big_clk,
  input  logic [WIDTH-1:0] up_in,
  input  logic             up_write_in,
  output logic             up_read_out,
  output logic [WIDTH-1:0] dn_out,
  output logic             dn_write_out,
  input  logic             dn_read_in,
  input  logic             flush,
  output logic [LVL_W-1:0] level
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [LVL_W-1:0] count_q, count_d;
  logic             push, pop, flush_en;
  logic [WIDTH-1:0] push_data;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) return '0;
    return p + PTR_W'(1);
  endfunction

  // Handshake: each side transfers one word in a strobe cycle where both its
  // request (up_write_in / dn_read_in) and the link's grant
  // (up_read_out / dn_write_out) are high; grants depend only on count.
  assign up_read_out  = rst_n & (count_q < LVL_W'(DEPTH));
  assign dn_write_out = (count_q != '0);
  assign dn_out       = dn_write_out ? mem_q[rd_ptr_q] : '0;
  assign level        = count_q;

  assign flush_en = posedge_big_clk & flush;
  assign push     = posedge_big_clk & up_write_in & up_read_out;
  assign pop      = posedge_big_clk & dn_read_in & dn_write_out;

  always_comb begin
    int v;
    v = int'($signed(up_in));
    push_data = up_in;
    if (SATURATE != 0) begin
      if (v > 999)       push_data = WIDTH'(999);
      else if (v < -999) push_data = WIDTH'(-999);
    end
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_en) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = ptr_next(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_next(rd_ptr_q);
      case ({push, pop})
        2'b10:   count_d = count_q + LVL_W'(1);
        2'b01:   count_d = count_q - LVL_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; only count decides which entries are live.
  always_ff @(posedge clk) begin
    if (push && !flush_en) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: tb/tb_xbus_fifo_link.sv
// Bench for xbus_fifo_link: two instances (clamping and raw) share stimulus
// and are compared against a queue model of the channel.
module tb_xbus_fifo_link;
  localparam int W     = 11;
  localparam int DEPTH = 4;
  localparam int LVL_W = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             big = 1'b0;
  logic [W-1:0]     up_in = '0;
  logic             up_write_in = 1'b0;
  logic             dn_read_in = 1'b0;
  logic             flush = 1'b0;

  logic             rdy1, avail1, rdy0, avail0;
  logic [W-1:0]     dout1, dout0;
  logic [LVL_W-1:0] lvl1, lvl0;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] exp_q[$];

  xbus_fifo_link #(.WIDTH(W), .DEPTH(DEPTH), .SATURATE(1)) dut_sat (
    .clk(clk), .rst_n(rst_n), .posedge_big_clk(big), .up_in(up_in),
    .up_write_in(up_write_in), .up_read_out(rdy1), .dn_out(dout1),
    .dn_write_out(avail1), .dn_read_in(dn_read_in), .flush(flush), .level(lvl1)
  );

  xbus_fifo_link #(.WIDTH(W), .DEPTH(DEPTH), .SATURATE(0)) dut_raw (
    .clk(clk), .rst_n(rst_n), .posedge_big_clk(big), .up_in(up_in),
    .up_write_in(up_write_in), .up_read_out(rdy0), .dn_out(dout0),
    .dn_write_out(avail0), .dn_read_in(dn_read_in), .flush(flush), .level(lvl0)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] sat(input logic [W-1:0] v);
    if ($signed(v) > 999)  return W'(999);
    if ($signed(v) < -999) return W'(-999);
    return v;
  endfunction

  function automatic logic [W-1:0] head_sat();
    return (exp_q.size() != 0) ? sat(exp_q[0]) : '0;
  endfunction

  function automatic logic [W-1:0] head_raw();
    return (exp_q.size() != 0) ? exp_q[0] : '0;
  endfunction

  // Inputs change just after the falling edge, leaving time to settle.
  task automatic drive(input logic s, input logic wr, input logic [W-1:0] d,
                       input logic rd, input logic fl);
    @(negedge clk);
    big = s; up_write_in = wr; up_in = d; dn_read_in = rd; flush = fl;
    #1;
  endtask

  // Advance the model across one rising edge using the inputs now applied.
  task automatic tick();
    bit do_push, do_pop;
    do_push = big && up_write_in && rst_n && (exp_q.size() < DEPTH);
    do_pop  = big && dn_read_in && (exp_q.size() != 0);
    @(posedge clk);
    if (!rst_n) exp_q.delete();
    else if (big && flush) exp_q.delete();
    else begin
      if (do_pop)  void'(exp_q.pop_front());
      if (do_push) exp_q.push_back(up_in);
    end
  endtask

  task automatic step(input logic s, input logic wr, input logic [W-1:0] d,
                      input logic rd, input logic fl);
    drive(s, wr, d, rd, fl);
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    n_checks++;
    if (rdy1 !== 1'b0 || avail1 !== 1'b0 || lvl1 !== '0 || dout1 !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: rdy=%b avail=%b level=%0d dout=%0d, want 0 0 0 0",
               rdy1, avail1, lvl1, dout1);
    end
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (rdy1 !== 1'b1 || avail1 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: rdy=%b avail=%b, want 1 0", rdy1, avail1);
    end
    // Buffered words vanish the moment reset is asserted mid-operation.
    step(1'b1, 1'b1, W'(11), 1'b0, 1'b0);
    step(1'b1, 1'b1, W'(22), 1'b0, 1'b0);
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    n_checks++;
    if (lvl1 !== '0 || avail1 !== 1'b0 || rdy1 !== 1'b0 || dout1 !== '0) begin
      n_fail++;
      $display("FAIL reset_midop: level=%0d avail=%b rdy=%b dout=%0d, want 0 0 0 0",
               lvl1, avail1, rdy1, dout1);
    end
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_fill_drain();
    logic [W-1:0] vals [4];
    vals[0] = W'(5); vals[1] = W'(-7); vals[2] = W'(999); vals[3] = W'(0);
    foreach (vals[i]) step(1'b1, 1'b1, vals[i], 1'b0, 1'b0);
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
    n_checks++;
    if (lvl1 !== LVL_W'(4) || rdy1 !== 1'b0) begin
      n_fail++;
      $display("FAIL fill_full: level=%0d rdy=%b, want 4 0", lvl1, rdy1);
    end
    foreach (vals[i]) begin
      drive(1'b1, 1'b0, '0, 1'b1, 1'b0);
      n_checks++;
      if (dout1 !== vals[i] || avail1 !== 1'b1) begin
        n_fail++;
        $display("FAIL drain_order[%0d]: got %0d avail=%b, want %0d avail=1",
                 i, $signed(dout1), avail1, $signed(vals[i]));
      end
      tick();
    end
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
    n_checks++;
    if (lvl1 !== '0 || avail1 !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_empty: level=%0d avail=%b, want 0 0", lvl1, avail1);
    end
  endtask

  task automatic test_saturation();
    logic [W-1:0] ins [4];
    logic [W-1:0] want_s [4];
    ins[0] = W'(1023); ins[1] = W'(-1024); ins[2] = W'(1000); ins[3] = W'(-999);
    want_s[0] = W'(999); want_s[1] = W'(-999); want_s[2] = W'(999); want_s[3] = W'(-999);
    foreach (ins[i]) step(1'b1, 1'b1, ins[i], 1'b0, 1'b0);
    foreach (ins[i]) begin
      drive(1'b1, 1'b0, '0, 1'b1, 1'b0);
      n_checks++;
      if (dout1 !== want_s[i]) begin
        n_fail++;
        $display("FAIL sat_on[%0d]: got %0d want %0d", i, $signed(dout1), $signed(want_s[i]));
      end
      n_checks++;
      if (dout0 !== ins[i]) begin
        n_fail++;
        $display("FAIL sat_off[%0d]: got %0d want %0d", i, $signed(dout0), $signed(ins[i]));
      end
      tick();
    end
  endtask

  task automatic test_simultaneous();
    step(1'b1, 1'b1, W'(100), 1'b0, 1'b0);
    step(1'b1, 1'b1, W'(200), 1'b0, 1'b0);
    step(1'b1, 1'b1, W'(300), 1'b1, 1'b0);
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
    n_checks++;
    if (lvl1 !== LVL_W'(2) || dout1 !== W'(200)) begin
      n_fail++;
      $display("FAIL simul_lvl2: level=%0d head=%0d, want 2 200", lvl1, dout1);
    end
    step(1'b1, 1'b1, W'(400), 1'b0, 1'b0);
    step(1'b1, 1'b1, W'(500), 1'b0, 1'b0);
    step(1'b1, 1'b1, W'(600), 1'b1, 1'b0);
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
    n_checks++;
    if (lvl1 !== LVL_W'(3) || dout1 !== W'(300)) begin
      n_fail++;
      $display("FAIL simul_full: level=%0d head=%0d, want 3 300", lvl1, dout1);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, '0, 1'b1, 1'b0);
      n_checks++;
      if (dout1 !== head_sat()) begin
        n_fail++;
        $display("FAIL simul_drain[%0d]: got %0d want %0d", i, dout1, head_sat());
      end
      tick();
    end
  endtask

  task automatic test_gating();
    step(1'b1, 1'b1, W'(42), 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, W'(i), 1'b1, 1'b1);
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
    n_checks++;
    if (lvl1 !== LVL_W'(1) || dout1 !== W'(42)) begin
      n_fail++;
      $display("FAIL gate_idle: level=%0d head=%0d, want 1 42", lvl1, dout1);
    end
    step(1'b1, 1'b0, '0, 1'b1, 1'b0);
    step(1'b1, 1'b0, '0, 1'b1, 1'b0);
    drive(1'b1, 1'b0, '0, 1'b1, 1'b0);
    n_checks++;
    if (lvl1 !== '0 || dout1 !== '0 || avail1 !== 1'b0) begin
      n_fail++;
      $display("FAIL gate_empty: level=%0d dout=%0d avail=%b, want 0 0 0", lvl1, dout1, avail1);
    end
    tick();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, W'(10 + i), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, W'(77), 1'b0, 1'b0);
      n_checks++;
      if (rdy1 !== 1'b0 || lvl1 !== LVL_W'(4)) begin
        n_fail++;
        $display("FAIL gate_full_hold[%0d]: rdy=%b level=%0d, want 0 4", i, rdy1, lvl1);
      end
      tick();
    end
    step(1'b1, 1'b1, W'(77), 1'b1, 1'b0);
    drive(1'b1, 1'b1, W'(77), 1'b0, 1'b0);
    n_checks++;
    if (rdy1 !== 1'b1 || lvl1 !== LVL_W'(3)) begin
      n_fail++;
      $display("FAIL gate_release: rdy=%b level=%0d, want 1 3", rdy1, lvl1);
    end
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, '0, 1'b1, 1'b0);
      n_checks++;
      if (dout1 !== head_sat()) begin
        n_fail++;
        $display("FAIL gate_drain[%0d]: got %0d want %0d", i, dout1, head_sat());
      end
      tick();
    end
  endtask

  task automatic test_wrap_flush();
    for (int i = 0; i < 9; i++) begin
      step(1'b1, 1'b1, W'(50 + i), 1'b0, 1'b0);
      drive(1'b1, 1'b0, '0, 1'b1, 1'b0);
      n_checks++;
      if (dout1 !== W'(50 + i)) begin
        n_fail++;
        $display("FAIL wrap[%0d]: got %0d want %0d", i, dout1, 50 + i);
      end
      tick();
    end
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, W'(-20 - i), 1'b0, 1'b0);
    step(1'b1, 1'b1, W'(123), 1'b1, 1'b1);
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
    n_checks++;
    if (lvl1 !== '0 || avail1 !== 1'b0 || rdy1 !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_level: level=%0d avail=%b rdy=%b, want 0 0 1", lvl1, avail1, rdy1);
    end
    step(1'b1, 1'b1, W'(-321), 1'b0, 1'b0);
    drive(1'b1, 1'b0, '0, 1'b1, 1'b0);
    n_checks++;
    if (dout1 !== W'(-321) || lvl1 !== LVL_W'(1)) begin
      n_fail++;
      $display("FAIL flush_next: head=%0d level=%0d, want -321 1", $signed(dout1), lvl1);
    end
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
            W'($urandom_range(0, 2047)), $urandom_range(0, 1) == 1,
            $urandom_range(0, 24) == 0);
      n_checks++;
      if (lvl1 !== LVL_W'(exp_q.size()) || lvl0 !== LVL_W'(exp_q.size())) begin
        n_fail++;
        $display("FAIL rand_level[%0d]: got %0d/%0d want %0d", i, lvl1, lvl0, exp_q.size());
      end
      n_checks++;
      if (rdy1 !== (exp_q.size() < DEPTH) || avail1 !== (exp_q.size() != 0)) begin
        n_fail++;
        $display("FAIL rand_flags[%0d]: rdy=%b avail=%b size=%0d", i, rdy1, avail1, exp_q.size());
      end
      n_checks++;
      if (dout1 !== head_sat() || dout0 !== head_raw()) begin
        n_fail++;
        $display("FAIL rand_head[%0d]: got %0d/%0d want %0d/%0d",
                 i, dout1, dout0, head_sat(), head_raw());
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_saturation();
    test_simultaneous();
    test_gating();
    test_wrap_flush();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
